booth_iter_counter: RTL

- Parametrised iteration counter and sequencer for the Booth multiplier datapath.
- Loads the iteration count for the configured operand width and radix, or a custom count.
- Decrements once per accepted Booth step and reports busy, last-iteration, zero and a one-cycle done pulse to the multiplier controller.
- Successor of the fixed 5-bit, load-16 step counter: adds width/radix generalisation, a custom load, hold, and completion handshake.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_iter_counter.sv | 118 +++++++++++
 2 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier iteration counter.
package booth_pkg;

  localparam int RADIX2 = 2;
  localparam int RADIX4 = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } booth_cnt_state_t;

  // Radix-4 recoding retires two multiplier bits per step.
  function automatic int booth_iter_count(input int operand_w, input int radix);
    int cnt_s;
    if (radix == RADIX4) begin
      cnt_s = operand_w / 2;
    end else begin
      cnt_s = operand_w;
    end
    return cnt_s;
  endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter/sequencer for the Booth multiplier datapath.
// Optional step-without-run detection: define BOOTH_CNT_UFLOW_CHK_EN.
module booth_iter_counter
  import booth_pkg::*;
#(
  parameter  int OPERAND_W = 16,
  parameter  int RADIX     = 2,
  localparam int ITER_DEF  = booth_iter_count(OPERAND_W, RADIX),
  localparam int CNT_W     = $clog2(ITER_DEF + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ldcnt,
  input  logic             ld_val_en,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             dcr,
  input  logic             hold,
  output logic [CNT_W-1:0] Data_out,
  output logic             busy,
  output logic             cnt_last,
  output logic             cnt_zero,
  output logic             done,
  output logic             uflow_err
);

  generate
    if (!((RADIX == RADIX2) || (RADIX == RADIX4))) begin : g_bad_radix
      $error("booth_iter_counter: RADIX must be 2 or 4");
    end
    if ((OPERAND_W < 2) || ((RADIX == RADIX4) && ((OPERAND_W % 2) != 0))) begin : g_bad_width
      $error("booth_iter_counter: OPERAND_W must be >= 2 and even for radix 4");
    end
  endgenerate

  booth_cnt_state_t state_r;

  // Sequencer: loads take priority over hold, hold over step; busy/done mirror state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      Data_out <= {CNT_W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (ldcnt) begin
      state_r  <= RUN;
      Data_out <= CNT_W'(ITER_DEF);
      busy     <= 1'b1;
      done     <= 1'b0;
    end else if (ld_val_en) begin
      Data_out <= ld_val;
      if (ld_val != {CNT_W{1'b0}}) begin
        state_r <= RUN;
        busy    <= 1'b1;
        done    <= 1'b0;
      end else begin
        state_r <= FINISH;
        busy    <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        RUN: begin
          if (hold) begin
            busy <= 1'b1;
          end else if (dcr) begin
            // A zero count in RUN cannot be loaded, but finishing keeps it from wrapping.
            if (Data_out > CNT_W'(1)) begin
              Data_out <= Data_out - CNT_W'(1);
            end else begin
              Data_out <= {CNT_W{1'b0}};
              state_r  <= FINISH;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            busy <= 1'b1;
          end
        end
        FINISH: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_zero = (Data_out == {CNT_W{1'b0}});
  assign cnt_last = (Data_out == CNT_W'(1)) && (state_r == RUN);

`ifdef BOOTH_CNT_UFLOW_CHK_EN
  // Sticky flag for a step reported while no count is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      uflow_err <= 1'b0;
    end else if (ldcnt || ld_val_en) begin
      uflow_err <= 1'b0;
    end else if (dcr && (state_r != RUN)) begin
      uflow_err <= 1'b1;
      $error("booth_iter_counter: dcr with no iteration running");
    end else begin
      uflow_err <= uflow_err;
    end
  end
`else
  assign uflow_err = 1'b0;
`endif

endmodule
